// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration-time helpers for the baud generator.
// Everything here is evaluated at elaboration; nothing divides at run time.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT   = 50_000_000;
  localparam int unsigned BAUD_DEFAULT       = 115_200;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Integer-truncated clocks-per-tick ratio. Only called from parameter expressions.
  function automatic int unsigned div_ratio(input int unsigned freq,
                                            input int unsigned rate);
    return freq / rate;
  endfunction

  // Counter width for a modulo-div counter; $clog2(div) always holds div-1.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/baud_tick_div.sv
// Modulo-DIV counter producing a registered one-clock tick every DIV clocks.
// The tick goes high on the edge where the counter wraps from DIV-1 to 0.
module baud_tick_div
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned   W    = cnt_width(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $fatal(1, "baud_tick_div: DIV must be at least 2");
    end
  endgenerate

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Free-running UART baud tick generator: tx_enb at the bit rate and rx_enb at
// OVERSAMPLE times the bit rate, from two independent divide counters.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tx_enb,
  output logic rx_enb
);

  localparam int unsigned TX_DIV = div_ratio(CLK_FREQ, BAUD);
  localparam int unsigned RX_DIV = div_ratio(CLK_FREQ, BAUD * OVERSAMPLE);

  generate
    if (TX_DIV < 2 || RX_DIV < 2) begin : g_bad_ratio
      $fatal(1, "baud_rate_gen: TX_DIV and RX_DIV must both be at least 2");
    end
  endgenerate

  // The two strobes are deliberately not phase-locked; OVERSAMPLE*RX_DIV
  // generally differs from TX_DIV because of truncation.
  baud_tick_div #(.DIV(TX_DIV)) u_tx_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tx_enb)
  );

  baud_tick_div #(.DIV(RX_DIV)) u_rx_div (
    .clk  (clk),
    .rst  (rst),
    .tick (rx_enb)
  );

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: default instance (434/27) and a 1 MHz /
// 9600 / x4 instance (104/26) sharing one clock and reset.
module tb_baud_rate_gen;

  localparam int CLK_PERIOD = 20;  // time units treated as ns (50 MHz)
  localparam int DIVS [4] = '{434, 27, 104, 26};  // tx, rx, small tx, small rx
  localparam int DRIFT_STEP = 2;   // 434 - 16*27

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_enb, rx_enb, tx_enb_s, rx_enb_s;

  int n_vectors     = 0;
  int n_miscompares = 0;

  int  n_bad     [4];
  int  first_hit [4];
  int  last_hit  [4];
  int  n_hit     [4];
  int  n_bad_gap [4];
  time last_t    [4];
  int  n_drift_bad;
  int  n_both;
  int  tx_seen;

  always #(CLK_PERIOD / 2) clk = ~clk;

  baud_rate_gen dut (
    .clk    (clk),
    .rst    (rst),
    .tx_enb (tx_enb),
    .rx_enb (rx_enb)
  );

  baud_rate_gen #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (9600),
    .OVERSAMPLE (4)
  ) dut_small (
    .clk    (clk),
    .rst    (rst),
    .tx_enb (tx_enb_s),
    .rx_enb (rx_enb_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_tx"},   32'(tx_enb),   0);
    check({tag, "_rx"},   32'(rx_enb),   0);
    check({tag, "_tx_s"}, 32'(tx_enb_s), 0);
    check({tag, "_rx_s"}, 32'(rx_enb_s), 0);
  endtask

  // Runs n edges after a reset release (caller already set rst=0 at a
  // falling edge); edge k's result is sampled at the following falling edge.
  task automatic run_edges(input int n, input int count_limit);
    logic [3:0] obs;
    int         off;
    for (int i = 0; i < 4; i++) begin
      n_bad[i] = 0; first_hit[i] = 0; last_hit[i] = 0;
      n_hit[i] = 0; n_bad_gap[i] = 0; last_t[i] = 0;
    end
    n_drift_bad = 0; n_both = 0; tx_seen = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      obs = {rx_enb_s, tx_enb_s, rx_enb, tx_enb};
      if (obs[0]) begin
        tx_seen++;
        off = obs[1] ? 0 : k - last_hit[1];
        if (off != (DRIFT_STEP * tx_seen) % DIVS[1]) n_drift_bad++;
      end
      if (obs[0] && obs[1]) n_both++;
      for (int i = 0; i < 4; i++) begin
        if (obs[i] !== ((k % DIVS[i]) == 0)) n_bad[i]++;
        if (obs[i]) begin
          if (first_hit[i] == 0) first_hit[i] = k;
          else if (($time - last_t[i]) != time'(DIVS[i] * CLK_PERIOD)) n_bad_gap[i]++;
          last_t[i]   = $time;
          last_hit[i] = k;
          if (k <= count_limit) n_hit[i]++;
        end
      end
    end
  endtask

  initial begin
    // Reset hold: both instances low from the very first edge.
    repeat (5) begin
      @(negedge clk);
      check_all_low("reset_hold");
    end

    // Free run: 12000 edges covers 200 us plus the first tx/rx coincidence.
    rst = 1'b0;
    run_edges(12000, 10000);
    check("first_tx_edge",   32'(first_hit[0]), 434);
    check("first_rx_edge",   32'(first_hit[1]), 27);
    check("first_tx_s_edge", 32'(first_hit[2]), 104);
    check("first_rx_s_edge", 32'(first_hit[3]), 26);
    check("tx_model_errs",   32'(n_bad[0]), 0);
    check("rx_model_errs",   32'(n_bad[1]), 0);
    check("tx_s_model_errs", 32'(n_bad[2]), 0);
    check("rx_s_model_errs", 32'(n_bad[3]), 0);
    check("tx_8680ns_gaps",  32'(n_bad_gap[0]), 0);
    check("rx_540ns_gaps",   32'(n_bad_gap[1]), 0);
    check("tx_s_gaps",       32'(n_bad_gap[2]), 0);
    check("rx_s_gaps",       32'(n_bad_gap[3]), 0);
    check("tx_pulses_200us",   32'(n_hit[0]), 23);
    check("rx_pulses_200us",   32'(n_hit[1]), 370);
    check("tx_s_pulses_200us", 32'(n_hit[2]), 96);
    check("rx_s_pulses_200us", 32'(n_hit[3]), 384);
    check("drift_errs",        32'(n_drift_bad), 0);
    check("tx_periods_seen",   32'(tx_seen), 27);
    check("coincident_ticks",  32'(n_both), 1);

    // Reset while running, then again on the edge where rx would strobe.
    rst = 1'b1;
    @(negedge clk);
    check_all_low("rerst");
    rst = 1'b0;
    run_edges(296, 0);
    check("pre_mid_tx_errs", 32'(n_bad[0]), 0);
    check("pre_mid_rx_errs", 32'(n_bad[1]), 0);
    check("pre_mid_rx_hits", 32'(last_hit[1]), 270);
    rst = 1'b1;
    @(negedge clk);
    check_all_low("mid_rst");
    rst = 1'b0;
    run_edges(500, 0);
    check("post_rst_first_tx",   32'(first_hit[0]), 434);
    check("post_rst_first_rx",   32'(first_hit[1]), 27);
    check("post_rst_first_tx_s", 32'(first_hit[2]), 104);
    check("post_rst_first_rx_s", 32'(first_hit[3]), 26);
    check("post_rst_tx_errs",    32'(n_bad[0]), 0);
    check("post_rst_rx_errs",    32'(n_bad[1]), 0);
    check("post_rst_tx_s_errs",  32'(n_bad[2]), 0);
    check("post_rst_rx_s_errs",  32'(n_bad[3]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
